// File: rtl/robo_seguidor_param.sv
// robo_seguidor_param: wall-following robot controller.
// Debounces three raw obstacle sensors, follows either the left or the right wall
// (latched when leaving IDLE), bounds in-place rotation with a stuck state, and
// counts advancing cycles in a saturating step counter.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   enable     1 = run, 0 = force IDLE
//   side_sel   0 = follow left wall, 1 = follow right wall (latched on IDLE->PROCURANDO)
//   head       raw front obstacle sensor
//   left       raw left wall sensor
//   right      raw right wall sensor
//   avancar    drive forward
//   girar      rotate in place
//   girar_dir  rotation direction, 1 = clockwise
//   stuck      high in TRAVADO
//   passos     saturating count of advancing cycles since last start
//   state_o    current state code
module robo_seguidor_param #(
   parameter int unsigned DEB_CYCLES = 3,
   parameter int unsigned ROT_MAX    = 16,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             side_sel,
   input  logic             head,
   input  logic             left,
   input  logic             right,
   output logic             avancar,
   output logic             girar,
   output logic             girar_dir,
   output logic             stuck,
   output logic [CNT_W-1:0] passos,
   output logic [2:0]       state_o
);

   localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
   localparam int unsigned ROT_W = (ROT_MAX > 1) ? $clog2(ROT_MAX) : 1;

   typedef enum logic [2:0] {
      StIdle       = 3'b000,
      StProcurando = 3'b001,
      StAcomp      = 3'b010,
      StRot        = 3'b011,
      StTravado    = 3'b100
   } state_e;

   state_e             state_q, state_d;
   logic [ROT_W-1:0]   rot_q, rot_d;
   logic               side_q, side_d;
   logic [CNT_W-1:0]   passos_q, passos_d;

   // Sensor index: 0 = head, 1 = left, 2 = right.
   logic [2:0]         raw;
   logic [2:0]         db_q;
   logic [DEB_W-1:0]   deb_cnt_q [3];

   logic               h, w;

   assign raw = {right, left, head};
   assign h   = db_q[0];
   assign w   = side_q ? db_q[2] : db_q[1];

   // Debounce: the counter tracks how long raw has disagreed with the debounced value.
   always_ff @(posedge clock) begin
      if (reset) begin
         db_q <= '0;
         for (int i = 0; i < 3; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (raw[i] == db_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
               db_q[i]      <= raw[i];
               deb_cnt_q[i] <= '0;
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         rot_q    <= '0;
         side_q   <= 1'b0;
         passos_q <= '0;
      end else begin
         state_q  <= state_d;
         rot_q    <= rot_d;
         side_q   <= side_d;
         passos_q <= passos_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rot_d    = rot_q;
      side_d   = side_q;
      passos_d = passos_q;

      if (avancar && (passos_q != '1)) begin
         passos_d = passos_q + CNT_W'(1);
      end

      if (!enable) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d  = StProcurando;
               side_d   = side_sel;
               passos_d = '0;
            end
            StProcurando: begin
               if (h) begin
                  state_d = StRot;
                  rot_d   = '0;
               end else if (w) begin
                  state_d = StAcomp;
               end
            end
            StAcomp: begin
               if (h && w) begin
                  state_d = StRot;
                  rot_d   = '0;
               end else if (!w) begin
                  state_d = StProcurando;
               end
            end
            StRot: begin
               // Regaining the wall beats the timeout on the same cycle.
               if (!h && w) begin
                  state_d = StAcomp;
               end else if (rot_q == ROT_W'(ROT_MAX - 1)) begin
                  state_d = StTravado;
               end else begin
                  rot_d = rot_q + ROT_W'(1);
               end
            end
            StTravado: begin
               state_d = StTravado;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_comb begin
      avancar = 1'b0;
      girar   = 1'b0;
      stuck   = 1'b0;
      unique case (state_q)
         StProcurando, StAcomp: avancar = 1'b1;
         StRot:                 girar   = 1'b1;
         StTravado:             stuck   = 1'b1;
         default:               ;
      endcase
   end

   assign girar_dir = ~side_q;
   assign passos    = passos_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_robo_seguidor_param.sv
module tb_robo_seguidor_param;

   localparam int DEB  = 3;
   localparam int ROTM = 16;
   localparam int CW   = 8;
   localparam int MAXP = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset, enable, side_sel, head, left, right;
   logic          avancar, girar, girar_dir, stuck;
   logic [CW-1:0] passos;
   logic [2:0]    state_o;

   int tests = 0;
   int fails = 0;

   // Reference model state (plain integers).
   int m_state, m_side, m_passos, m_dwell;
   int m_db [3];
   int m_run [3];

   robo_seguidor_param #(
      .DEB_CYCLES(DEB),
      .ROT_MAX   (ROTM),
      .CNT_W     (CW)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .side_sel (side_sel),
      .head     (head),
      .left     (left),
      .right    (right),
      .avancar  (avancar),
      .girar    (girar),
      .girar_dir(girar_dir),
      .stuck    (stuck),
      .passos   (passos),
      .state_o  (state_o)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state  = 0;
      m_side   = 0;
      m_passos = 0;
      m_dwell  = 0;
      for (int i = 0; i < 3; i++) begin
         m_db[i]  = 0;
         m_run[i] = 0;
      end
   endtask

   // One clock edge of the behavioural model, from the inputs present at the edge.
   task automatic model_step();
      int h, w, nxt;
      int rawv [3];
      rawv[0] = int'(head);
      rawv[1] = int'(left);
      rawv[2] = int'(right);
      if (reset) begin
         model_reset();
         return;
      end
      h   = m_db[0];
      w   = (m_side != 0) ? m_db[2] : m_db[1];
      nxt = m_state;
      if ((m_state == 1 || m_state == 2) && m_passos < MAXP) m_passos++;
      if (!enable) begin
         nxt = 0;
      end else begin
         case (m_state)
            0: begin nxt = 1; m_side = int'(side_sel); m_passos = 0; end
            1: if (h != 0) nxt = 3; else if (w != 0) nxt = 2;
            2: if (h != 0 && w != 0) nxt = 3; else if (w == 0) nxt = 1;
            3: if (h == 0 && w != 0) nxt = 2; else if (m_dwell == ROTM - 1) nxt = 4;
            default: ;
         endcase
      end
      // m_dwell = completed cycles already spent in ROT during this visit.
      if (nxt == 3) m_dwell = (m_state == 3) ? m_dwell + 1 : 0;
      else          m_dwell = 0;
      m_state = nxt;
      for (int i = 0; i < 3; i++) begin
         if (rawv[i] == m_db[i]) begin
            m_run[i] = 0;
         end else begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_db[i]  = rawv[i];
               m_run[i] = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("state_o",   32'(state_o),   32'(m_state));
      chk("avancar",   32'(avancar),   32'((m_state == 1 || m_state == 2) ? 1 : 0));
      chk("girar",     32'(girar),     32'((m_state == 3) ? 1 : 0));
      chk("stuck",     32'(stuck),     32'((m_state == 4) ? 1 : 0));
      chk("passos",    32'(passos),    32'(m_passos));
      chk("girar_dir", 32'(girar_dir), 32'((m_side == 0) ? 1 : 0));
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int rc;
      model_reset();

      // Reset with random inputs.
      reset    = 1'b1;
      enable   = 1'($urandom);
      side_sel = 1'($urandom);
      head     = 1'($urandom);
      left     = 1'($urandom);
      right    = 1'($urandom);
      ticks(2);
      chk("rst_state", 32'(state_o), 0);
      chk("rst_passos", 32'(passos), 0);
      chk("rst_dir", 32'(girar_dir), 1);

      // Forward and saturation.
      reset = 1'b0; enable = 1'b1; side_sel = 1'b0;
      head = 1'b0; left = 1'b0; right = 1'b0;
      tick();
      chk("enable_proc", 32'(state_o), 1);
      chk("passos_start", 32'(passos), 0);
      tick();
      chk("passos_one", 32'(passos), 1);
      ticks(MAXP + 5);
      chk("passos_sat", 32'(passos), MAXP);
      enable = 1'b0;
      tick();
      chk("disable_idle", 32'(state_o), 0);
      chk("idle_hold", 32'(passos), MAXP);
      enable = 1'b1;
      tick();
      chk("reenable_clear", 32'(passos), 0);

      // Follow / rotate on the left wall.
      left = 1'b1;
      ticks(3);
      chk("acomp_not_yet", 32'(state_o), 1);
      tick();
      chk("acomp_edge4", 32'(state_o), 2);
      head = 1'b1;
      ticks(4);
      chk("rot_edge4", 32'(state_o), 3);
      chk("rot_dir_left", 32'(girar_dir), 1);
      head = 1'b0;
      ticks(4);
      chk("rot_exit", 32'(state_o), 2);

      // Two-cycle head glitch is rejected.
      head = 1'b1;
      ticks(2);
      head = 1'b0;
      ticks(5);
      chk("glitch", 32'(state_o), 2);

      // Stuck: rotation never finds the wall.
      head = 1'b1; left = 1'b0;
      rc = 0;
      for (int k = 0; k < 60 && state_o != 3'b100; k++) begin
         tick();
         if (state_o == 3'b011) rc++;
      end
      chk("rot_dwell", 32'(rc), ROTM);
      chk("stuck_state", 32'(state_o), 4);
      ticks(5);
      chk("stuck_hold", 32'(stuck), 1);
      enable = 1'b0;
      tick();
      chk("stuck_release", 32'(stuck), 0);

      // Reset in the middle of a rotation.
      enable = 1'b1;
      ticks(2);
      chk("rot_again", 32'(state_o), 3);
      reset = 1'b1;
      tick();
      chk("rst_in_rot", 32'(state_o), 0);
      reset = 1'b0; head = 1'b0;
      tick();

      // Right-wall following.
      enable = 1'b0;
      tick();
      side_sel = 1'b1; enable = 1'b1;
      tick();
      chk("right_dir", 32'(girar_dir), 0);
      left = 1'b1;
      ticks(6);
      chk("left_ignored", 32'(state_o), 1);
      right = 1'b1;
      ticks(4);
      chk("right_acomp", 32'(state_o), 2);
      side_sel = 1'b0;
      head = 1'b1;
      ticks(4);
      chk("right_rot", 32'(state_o), 3);
      chk("right_rot_dir", 32'(girar_dir), 0);
      head = 1'b0;
      side_sel = 1'b1;
      ticks(4);
      chk("right_exit", 32'(state_o), 2);

      // Randomised run against the model.
      for (int k = 0; k < 2500; k++) begin
         if ($urandom_range(0, 7) == 0) head  = ~head;
         if ($urandom_range(0, 7) == 0) left  = ~left;
         if ($urandom_range(0, 7) == 0) right = ~right;
         if ($urandom_range(0, 59) == 0) enable = ~enable;
         reset    = ($urandom_range(0, 299) == 0);
         side_sel = 1'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
